// File: rtl/led_row_scanner.sv
// 8x8 frame buffer scanned one row at a time onto an LED matrix, with a blanking gap per row.
// Optional ROW_BLINK_EN adds blink_en/blink_row ports to flash a single row.
module led_row_scanner #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned BLINK_DIV    = 12500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       clr,
`ifdef ROW_BLINK_EN
  input  logic       blink_en,
  input  logic [2:0] blink_row,
`endif
  output logic [7:0] row_sel,
  output logic [7:0] col_data,
  output logic       frame_tick
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  if (SCAN_DIV < BLANK_CYCLES + 2 || BLINK_DIV < 2) begin : g_param_check
    $error("led_row_scanner: SCAN_DIV must be >= BLANK_CYCLES+2 and BLINK_DIV >= 2");
  end

  logic [7:0]    buffer [8];
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [2:0]    scan_row;
  logic [2:0]    scan_row_next;
  logic          wrap;
  logic          blank_slot;
  logic          blink_mask;

  always_comb begin
    wrap          = (cnt == CW'(SCAN_DIV - 1));
    cnt_next      = wrap ? '0 : cnt + 1'b1;
    scan_row_next = wrap ? scan_row + 3'd1 : scan_row;
    blank_slot    = (cnt_next < CW'(BLANK_CYCLES));
  end

`ifdef ROW_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_DIV);

  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_next;
  logic          blink_on;
  logic          blink_on_next;
  logic          blink_wrap;

  always_comb begin
    blink_wrap     = (blink_cnt == BW'(BLINK_DIV - 1));
    blink_cnt_next = blink_wrap ? '0 : blink_cnt + 1'b1;
    blink_on_next  = blink_wrap ? ~blink_on : blink_on;
    blink_mask     = blink_en && !blink_on_next && (scan_row_next == blink_row);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      blink_cnt <= blink_cnt_next;
      blink_on  <= blink_on_next;
    end
  end
`else
  always_comb begin
    blink_mask = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      scan_row <= '0;
    end else begin
      cnt      <= cnt_next;
      scan_row <= scan_row_next;
    end
  end

  // Clear has priority over a same-cycle write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 8; i++) buffer[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < 8; i++) buffer[i] <= '0;
    end else if (wr_en) begin
      buffer[wr_row] <= wr_data;
    end
  end

  // Outputs are registered from next-state values so they align with cnt/scan_row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_sel    <= 8'h01;
      col_data   <= '0;
      frame_tick <= 1'b0;
    end else begin
      row_sel    <= 8'h01 << scan_row_next;
      col_data   <= (blank_slot || blink_mask) ? '0 : buffer[scan_row_next];
      frame_tick <= wrap && (scan_row == 3'd7);
    end
  end

endmodule

// File: tb/tb_led_row_scanner.sv
// Scoreboard bench for led_row_scanner: a time-based model predicts each cycle's outputs.
// Define ROW_BLINK_EN for both files to exercise the blink feature.
module tb_led_row_scanner;

  localparam int unsigned S  = 8;
  localparam int unsigned B  = 2;
  localparam int unsigned BD = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_data = '0;
  logic       clr = 1'b0;
`ifdef ROW_BLINK_EN
  logic       blink_en = 1'b0;
  logic [2:0] blink_row = '0;
`endif
  logic [7:0] row_sel;
  logic [7:0] col_data;
  logic       frame_tick;

  always #5 clk = ~clk;

  led_row_scanner #(.SCAN_DIV(S), .BLANK_CYCLES(B), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .clr        (clr),
`ifdef ROW_BLINK_EN
    .blink_en   (blink_en),
    .blink_row  (blink_row),
`endif
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [7:0] rs;
    logic [7:0] cd;
    logic       ft;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mbuf [8];
  int unsigned t;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs for the state reached n edges after reset release.
  function automatic exp_t predict(input int unsigned n);
    exp_t       e;
    logic [2:0] row;
    int unsigned c;
    row  = 3'((n / S) % 8);
    c    = n % S;
    e.rs = 8'h01 << row;
    e.cd = (c < B) ? 8'h00 : mbuf[row];
`ifdef ROW_BLINK_EN
    if (blink_en && ((n / BD) % 2 == 1) && (row == blink_row)) e.cd = 8'h00;
`endif
    e.ft = ((n % (8 * S)) == 0);
    return e;
  endfunction

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < 8; i++) mbuf[i] = 8'h00;
  endtask

  task automatic step(input logic we, input logic [2:0] wr, input logic [7:0] wd, input logic cl);
    exp_t e;
    wr_en   = we;
    wr_row  = wr;
    wr_data = wd;
    clr     = cl;
    sb.push_back(predict(t + 1));
    if (cl) begin
      for (int i = 0; i < 8; i++) mbuf[i] = 8'h00;
    end else if (we) begin
      mbuf[wr] = wd;
    end
    t++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("row_sel@%0d", t), 32'(row_sel), 32'(e.rs));
    check($sformatf("col_data@%0d", t), 32'(col_data), 32'(e.cd));
    check($sformatf("frame_tick@%0d", t), 32'(frame_tick), 32'(e.ft));
    wr_en = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic idle(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) step(1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_sel"}, 32'(row_sel), 32'h01);
    check({tag, "_col_data"}, 32'(col_data), 32'h00);
    check({tag, "_frame_tick"}, 32'(frame_tick), 32'h0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Empty buffer: scan cadence and frame tick only.
    idle(72);

    // Rows 0 and 3 with blanking at the start of each slot.
    step(1'b1, 3'd0, 8'hE0, 1'b0);
    step(1'b1, 3'd3, 8'h1C, 1'b0);
    idle(64);

    // Write the displayed row after the blanking gap.
    for (int unsigned g = 0; g < 64 && !(((t / S) % 8 == 2) && (t % S >= 3)); g++)
      step(1'b0, 3'd0, 8'h00, 1'b0);
    step(1'b1, 3'd2, 8'hFF, 1'b0);
    idle(16);

    // Fill, back-to-back writes to one row, then clear colliding with a write.
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 8'hAA, 1'b0);
    step(1'b1, 3'd1, 8'h55, 1'b0);
    step(1'b1, 3'd1, 8'hAA, 1'b0);
    idle(8);
    step(1'b1, 3'd5, 8'h3C, 1'b1);
    idle(64);

    // Asynchronous reset in the middle of row 4.
    step(1'b1, 3'd4, 8'h0F, 1'b0);
    step(1'b1, 3'd0, 8'h81, 1'b0);
    for (int unsigned g = 0; g < 64 && !(((t / S) % 8 == 4) && (t % S == 4)); g++)
      step(1'b0, 3'd0, 8'h00, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrow");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    idle(64);

`ifdef ROW_BLINK_EN
    blink_en  = 1'b1;
    blink_row = 3'd0;
    step(1'b1, 3'd0, 8'hE0, 1'b0);
    step(1'b1, 3'd2, 8'h3C, 1'b0);
    idle(128);
    blink_row = 3'd2;
    idle(128);
    blink_en = 1'b0;
    idle(32);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
